// File: rtl/ibex_taint_mem_responder.sv
// Word memory with a bitwise shadow taint array serving one Ibex req/gnt port.
// Ports: req/gnt/addr/we/wdata/strb in, rdata out, *_t0 taints, inject_* bench taint, taint_addr_wr_o sticky flag.
`timescale 1ns/1ps
module ibex_taint_mem_responder #(
  parameter int unsigned MemDepth = 1 << 15,
  parameter int unsigned GntDelay = 0,
  localparam int unsigned Aw = $clog2(MemDepth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [Aw-1:0] addr_i,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  input  logic [31:0]   strb_i,
  output logic [31:0]   rdata_o,
  input  logic          req_i_t0,
  input  logic [Aw-1:0] addr_i_t0,
  input  logic          we_i_t0,
  input  logic [31:0]   wdata_i_t0,
  input  logic [31:0]   strb_i_t0,
  output logic [31:0]   rdata_o_t0,
  input  logic          inject_valid_i,
  input  logic [Aw-1:0] inject_addr_i,
  input  logic [31:0]   inject_mask_i,
  output logic          taint_addr_wr_o
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT
  } state_e;

  localparam int unsigned CntW = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(GntDelay);
  localparam logic [CntW-1:0] CntLoad = CntW'(GntDelay - 1);
  localparam logic [Aw-1:0] LastAddr = Aw'(MemDepth - 1);
  localparam bit NoDelay = (GntDelay == 0);

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Aw-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rdata_t0_q, rdata_t0_d;
  logic taint_addr_wr_q, taint_addr_wr_d;

  logic [31:0] mem_q [MemDepth];
  logic [31:0] taint_q [MemDepth];

  logic ctl_t, rd_fire, wr_fire, inj_en;
  logic [31:0] wr_data, wr_taint, inj_base;

  assign gnt_o = req_i & ((state_q == ST_IDLE && NoDelay) ||
                          (state_q == ST_WAIT && cnt_q == '0));

  assign ctl_t = req_i_t0 | we_i_t0 | (|addr_i_t0);
  assign rd_fire = gnt_o & ~we_i;
  assign wr_fire = gnt_o & we_i;
  assign inj_en = inject_valid_i & (state_q != ST_CLEAR);

  assign wr_data = (mem_q[addr_i] & ~strb_i) | (wdata_i & strb_i);
  assign wr_taint = ctl_t ? '1 :
    (taint_q[addr_i] & ~strb_i) | (wdata_i_t0 & strb_i) | strb_i_t0;

  // Same-word injection ORs on top of the freshly written taint.
  assign inj_base = (wr_fire && inject_addr_i == addr_i) ?
    wr_taint : taint_q[inject_addr_i];

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastAddr) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_i && !NoDelay) begin
          state_d = ST_WAIT;
          cnt_d = CntLoad;
        end
      end
      ST_WAIT: begin
        if (!req_i || cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d = CntInit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    rdata_t0_d = rdata_t0_q;
    if (rd_fire) begin
      rdata_d = mem_q[addr_i];
      rdata_t0_d = ctl_t ? '1 : taint_q[addr_i];
    end
    taint_addr_wr_d = taint_addr_wr_q | (wr_fire & ctl_t);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q <= CntInit;
      clr_ptr_q <= '0;
      rdata_q <= '0;
      rdata_t0_q <= '0;
      taint_addr_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clr_ptr_q <= clr_ptr_d;
      rdata_q <= rdata_d;
      rdata_t0_q <= rdata_t0_d;
      taint_addr_wr_q <= taint_addr_wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[addr_i] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      taint_q[clr_ptr_q] <= '0;
    end else begin
      if (wr_fire) taint_q[addr_i] <= wr_taint;
      if (inj_en) taint_q[inject_addr_i] <= inj_base | inject_mask_i;
    end
  end

  assign rdata_o = rdata_q;
  assign rdata_o_t0 = rdata_t0_q;
  assign taint_addr_wr_o = taint_addr_wr_q;

endmodule
